// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: sequential load/store unit with req/gnt/rvalid memory handshake,
// misaligned-access splitting into two beats and sign/zero-extended loads.
module lsu_mem_ctrl #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_store_i,
    input  logic [2:0]          req_funct3_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [XLEN-1:0]     req_wdata_i,
    output logic                rsp_valid_o,
    output logic [XLEN-1:0]     rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                mem_cs_o,
    output logic                mem_wr_o,
    input  logic                mem_gnt_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [XLEN/8-1:0]   mem_mask_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    typedef enum logic [2:0] {IDLE, ERR, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_e;
    state_e            state_q, state_d;
    logic              store_q, split_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [OW-1:0]     off_q;
    logic [3:0]        size_q;
    logic [XLEN-1:0]   wdata_q, beat0_q, rdata_q;
    logic [3:0]        size;
    logic [OW-1:0]     off;
    logic              legal, mis, err, accept, beat;
    logic [2*NB-1:0]   m2;
    logic [2*XLEN-1:0] w2;
    logic [XLEN-1:0]   b0, b1, sh, ld;
    logic              sx;
    always_comb begin
        size   = 4'd1 << req_funct3_i[1:0];
        off    = req_addr_i[OW-1:0];
        legal  = req_funct3_i != 3'b111
                 && (XLEN == 64 || (req_funct3_i[1:0] != 2'b11 && req_funct3_i != 3'b110))
                 && !(req_store_i && req_funct3_i[2]);
        mis    = 5'(off) + 5'(size) > 5'(NB);
        err    = !legal || (mis && MISALIGN_EN == 0);
        accept = req_valid_i && req_ready_o;
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      state_d = req_valid_i ? (err ? ERR : BEAT0) : IDLE;
            BEAT0:     state_d = mem_gnt_i ? WAIT0 : BEAT0;
            WAIT0:     state_d = mem_rvalid_i ? (split_q ? BEAT1 : RESP) : WAIT0;
            BEAT1:     state_d = mem_gnt_i ? WAIT1 : BEAT1;
            WAIT1:     state_d = mem_rvalid_i ? RESP : WAIT1;
            default:   state_d = IDLE;
        endcase
    end
    // Both beats are views of one double-width shifted mask/data vector.
    always_comb begin
        beat        = state_q == BEAT0 || state_q == BEAT1;
        m2          = (((2*NB)'(1) << size_q) - (2*NB)'(1)) << off_q;
        w2          = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
        req_ready_o = state_q == IDLE;
        rsp_valid_o = state_q == RESP || state_q == ERR;
        rsp_err_o   = state_q == ERR;
        rsp_rdata_o = rdata_q;
        mem_cs_o    = !beat;
        mem_wr_o    = beat ? !store_q : 1'b1;
        mem_addr_o  = state_q == BEAT0 ? addr_q : state_q == BEAT1 ? addr_q + ADDR_W'(NB) : '0;
        mem_mask_o  = state_q == BEAT0 ? m2[NB-1:0] : state_q == BEAT1 ? m2[2*NB-1:NB] : '0;
        mem_wdata_o = state_q == BEAT0 ? w2[XLEN-1:0] : state_q == BEAT1 ? w2[2*XLEN-1:XLEN] : '0;
    end
    // Load assembly uses the beat arriving this cycle, so the result is ready as RESP starts.
    always_comb begin
        b0 = state_q == WAIT1 ? beat0_q : mem_rdata_i;
        b1 = state_q == WAIT1 ? mem_rdata_i : '0;
        sh = XLEN'({b1, b0} >> {off_q, 3'b000});
        sx = !f3_q[2];
        ld = size_q == 4'd1 ? (sx ? XLEN'($signed(sh[7:0])) : XLEN'(sh[7:0])) :
             size_q == 4'd2 ? (sx ? XLEN'($signed(sh[15:0])) : XLEN'(sh[15:0])) :
             size_q == 4'd4 ? (sx ? XLEN'($signed(sh[31:0])) : XLEN'(sh[31:0])) : sh;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            split_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q <= req_store_i;
                split_q <= mis;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i & ~ADDR_W'(NB - 1);
                off_q   <= off;
                size_q  <= size;
                wdata_q <= req_wdata_i;
            end
            if (state_q == WAIT0 && mem_rvalid_i)
                beat0_q <= mem_rdata_i;
            if (state_d != state_q && (state_d == ERR || state_d == RESP))
                rdata_q <= (state_d == ERR || store_q) ? '0 : ld;
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks on a 32-bit splitting unit, a 32-bit rejecting
// unit and a 64-bit unit, all fed from one shared stimulus set.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_store = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0, mem_rdata = '0;
    int          checks = 0, failures = 0;

    logic        a_ready, a_rv, a_err, a_cs, a_wr;
    logic [31:0] a_rdata, a_addr, a_wdata;
    logic [3:0]  a_mask;
    logic        n_ready, n_rv, n_err, n_cs, n_wr;
    logic [31:0] n_rdata, n_addr, n_wdata;
    logic [3:0]  n_mask;
    logic        d_ready, d_rv, d_err, d_cs, d_wr;
    logic [63:0] d_rdata, d_wdata;
    logic [31:0] d_addr;
    logic [7:0]  d_mask;

    lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(a_ready),
        .req_store_i(req_store), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata[31:0]), .rsp_valid_o(a_rv), .rsp_rdata_o(a_rdata),
        .rsp_err_o(a_err), .mem_cs_o(a_cs), .mem_wr_o(a_wr), .mem_gnt_i(mem_gnt),
        .mem_addr_o(a_addr), .mem_mask_o(a_mask), .mem_wdata_o(a_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata[31:0]));
    lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(0)) u_n (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(n_ready),
        .req_store_i(req_store), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata[31:0]), .rsp_valid_o(n_rv), .rsp_rdata_o(n_rdata),
        .rsp_err_o(n_err), .mem_cs_o(n_cs), .mem_wr_o(n_wr), .mem_gnt_i(mem_gnt),
        .mem_addr_o(n_addr), .mem_mask_o(n_mask), .mem_wdata_o(n_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata[31:0]));
    lsu_mem_ctrl #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1)) u_d (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(d_ready),
        .req_store_i(req_store), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(d_rv), .rsp_rdata_o(d_rdata),
        .rsp_err_o(d_err), .mem_cs_o(d_cs), .mem_wr_o(d_wr), .mem_gnt_i(mem_gnt),
        .mem_addr_o(d_addr), .mem_mask_o(d_mask), .mem_wdata_o(d_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_ready"}, a_ready, 1);
        chk({tag, "_rv"}, a_rv, 0);
        chk({tag, "_err"}, a_err, 0);
        chk({tag, "_rdata"}, a_rdata, 0);
        chk({tag, "_cs"}, a_cs, 1);
        chk({tag, "_wr"}, a_wr, 1);
        chk({tag, "_addr"}, a_addr, 0);
        chk({tag, "_mask"}, a_mask, 0);
        chk({tag, "_wdata"}, a_wdata, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_a("rst");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic request(input logic st, input logic [2:0] f3, input logic [31:0] ad,
                           input logic [63:0] wd);
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_addr = ad;
        req_wdata = wd;
    endtask

    initial begin
        do_reset();

        // LB at 0x1003, word 0x80FF_1234 -> 0xFFFF_FF80 at cycle 3
        request(1'b0, 3'b000, 32'h1003, 64'h0);
        chk("lb_ready0", a_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("lb_ready1", a_ready, 0);
        chk("lb_cs", a_cs, 0);
        chk("lb_wr", a_wr, 1);
        chk("lb_addr", a_addr, 32'h1000);
        chk("lb_mask", a_mask, 4'b1000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("lb_ready2", a_ready, 0);
        chk("lb_cs2", a_cs, 1);
        chk("lb_rv2", a_rv, 0);
        mem_rvalid = 1'b1;
        mem_rdata = 64'h80FF_1234;
        tick();
        mem_rvalid = 1'b0;
        chk("lb_rv3", a_rv, 1);
        chk("lb_ready3", a_ready, 0);
        chk("lb_err3", a_err, 0);
        chk("lb_rdata", a_rdata, 32'hFFFF_FF80);
        tick();
        chk("lb_rv4", a_rv, 0);
        chk("lb_ready4", a_ready, 1);
        chk("lb_hold", a_rdata, 32'hFFFF_FF80);

        // SW at 0x2002 split into two beats
        do_reset();
        request(1'b1, 3'b010, 32'h2002, 64'hAABB_CCDD);
        tick();
        req_valid = 1'b0;
        chk("sw_b0_cs", a_cs, 0);
        chk("sw_b0_wr", a_wr, 0);
        chk("sw_b0_addr", a_addr, 32'h2000);
        chk("sw_b0_mask", a_mask, 4'b1100);
        chk("sw_b0_data", a_wdata, 32'hCCDD_0000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("sw_b1_cs", a_cs, 0);
        chk("sw_b1_wr", a_wr, 0);
        chk("sw_b1_addr", a_addr, 32'h2004);
        chk("sw_b1_mask", a_mask, 4'b0011);
        chk("sw_b1_data", a_wdata, 32'h0000_AABB);
        chk("sw_b1_rv", a_rv, 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("sw_w1_rv", a_rv, 0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("sw_rv", a_rv, 1);
        chk("sw_err", a_err, 0);
        chk("sw_rdata", a_rdata, 0);
        tick();
        chk("sw_rv_end", a_rv, 0);

        // LHU at 0x0003 rejected when splitting is disabled
        do_reset();
        request(1'b0, 3'b101, 32'h0003, 64'h0);
        tick();
        req_valid = 1'b0;
        chk("rej_cs", n_cs, 1);
        chk("rej_rv", n_rv, 1);
        chk("rej_err", n_err, 1);
        chk("rej_rdata", n_rdata, 0);
        tick();
        chk("rej_rv_end", n_rv, 0);
        chk("rej_ready", n_ready, 1);
        chk("rej_cs_end", n_cs, 1);

        // illegal store size code is an error even with splitting enabled
        do_reset();
        request(1'b1, 3'b100, 32'h0000, 64'h0);
        tick();
        req_valid = 1'b0;
        chk("ill_cs", a_cs, 1);
        chk("ill_err", a_err, 1);
        chk("ill_rv", a_rv, 1);
        tick();

        // LW at 0x10 with grant withheld 4 cycles and spurious rvalid while waiting
        do_reset();
        request(1'b0, 3'b010, 32'h0010, 64'h0);
        tick();
        req_valid = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 64'hDEAD_BEEF;
        chk("stall_cs1", a_cs, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_cs", a_cs, 0);
            chk("stall_addr", a_addr, 32'h10);
            chk("stall_mask", a_mask, 4'b1111);
            chk("stall_rv", a_rv, 0);
        end
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("stall_rv6", a_rv, 0);
        mem_rvalid = 1'b1;
        mem_rdata = 64'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("stall_rv7", a_rv, 1);
        chk("stall_rdata", a_rdata, 32'h1234_5678);
        tick();

        // XLEN=64 LWU and LW at 0x100C
        do_reset();
        request(1'b0, 3'b110, 32'h100C, 64'h0);
        tick();
        req_valid = 1'b0;
        chk("lwu_addr", d_addr, 32'h1008);
        chk("lwu_mask", d_mask, 8'hF0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 64'h8765_4321_0000_0000;
        tick();
        mem_rvalid = 1'b0;
        chk("lwu_rv", d_rv, 1);
        chk("lwu_rdata", d_rdata, 64'h0000_0000_8765_4321);
        tick();
        request(1'b0, 3'b010, 32'h100C, 64'h0);
        tick();
        req_valid = 1'b0;
        chk("lw64_mask", d_mask, 8'hF0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("lw64_rv", d_rv, 1);
        chk("lw64_rdata", d_rdata, 64'hFFFF_FFFF_8765_4321);
        tick();

        // reset in WAIT1 of a split load, then a clean aligned LW
        do_reset();
        request(1'b0, 3'b010, 32'h2002, 64'h0);
        tick();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 64'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        chk("mid_b1_addr", a_addr, 32'h2004);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("mid_w1_cs", a_cs, 1);
        chk("mid_w1_ready", a_ready, 0);
        rst_n = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        check_reset_a("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("post_rst_rv", a_rv, 0);
        chk("post_rst_ready", a_ready, 1);
        request(1'b0, 3'b010, 32'h0040, 64'h0);
        tick();
        req_valid = 1'b0;
        chk("post_cs", a_cs, 0);
        chk("post_addr", a_addr, 32'h40);
        chk("post_rv1", a_rv, 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("post_rv2", a_rv, 0);
        mem_rvalid = 1'b1;
        mem_rdata = 64'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("post_rv3", a_rv, 1);
        chk("post_rdata", a_rdata, 32'hCAFE_F00D);
        tick();
        chk("post_rv4", a_rv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised sequential load/store unit between the core's memory stage and a single-port data memory.
- Adds a request/grant/valid handshake, wait-state tolerance, misaligned-access splitting into two bus beats, RV64 access sizes, and error signalling.
- Load results are byte-lane selected and sign/zero-extended to XLEN.
- Memory strobe polarities are kept: cs active-low, wr low = write.

Parameters:
- XLEN, 32, data/bus width; legal values 32 or 64. NB = XLEN/8 bytes per beat.
- ADDR_W, 32, byte-address width.
- MISALIGN_EN, 1, 1 = split misaligned accesses into two beats; 0 = reject them with rsp_err.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  access request from core
- req_ready  out  1  unit can accept request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign code
- req_addr  in  ADDR_W  byte address (alu result)
- req_wdata  in  XLEN  store data (rs2)
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  XLEN  extended load data; 0 for stores/errors
- rsp_err  out  1  valid with rsp_valid: illegal funct3 or rejected misalignment
- mem_cs  out  1  chip select, active-low
- mem_wr  out  1  0 = write, 1 = read
- mem_gnt  in  1  memory accepts beat this cycle
- mem_addr  out  ADDR_W  NB-aligned beat address
- mem_mask  out  NB  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rvalid  in  1  beat completion (read data or write ack)
- mem_rdata  in  XLEN  read beat data

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_cs=1, mem_wr=1, mem_addr=0, mem_mask=0, mem_wdata=0.
  - Reset mid-transaction abandons it with no response.
- Sizes:
  - funct3 000/100 = byte signed/unsigned; 001/101 = half; 010 = word signed; 110 = word unsigned (XLEN=64 only); 011 = double (XLEN=64 only).
  - Any other code, or a store with funct3[2]=1, is illegal.
- Request accept:
  - A request is accepted when req_valid & req_ready.
  - The unit registers all request fields, off = addr mod NB, and size.
  - req_ready=1 only in IDLE.
- FSM states: IDLE -> {ERR | BEAT0}; BEAT0 -> WAIT0 on gnt; WAIT0 -> {BEAT1 if split | RESP} on rvalid; BEAT1 -> WAIT1 on gnt; WAIT1 -> RESP on rvalid; RESP -> IDLE.
- ERR path:
  - Taken for illegal funct3, or when off+size > NB and MISALIGN_EN=0.
  - Issues no memory beat.
  - Next cycle drives rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Beat outputs:
  - In BEAT0/BEAT1: mem_cs=0, mem_wr=~store.
  - Outputs are held stable until mem_gnt; a grant may arrive after any number of cycles.
  - mem_cs=1 in all other states.
- Beat 0:
  - mem_addr = addr & ~(NB-1).
  - mem_mask = ((1<<size)-1) << off, truncated to NB bits.
  - mem_wdata = wdata << 8*off, truncated.
- Beat 1 (split when off+size > NB):
  - mem_addr = beat0 address + NB; wraps modulo 2^ADDR_W.
  - mem_mask = ((1<<size)-1) >> (NB-off).
  - mem_wdata = wdata >> 8*(NB-off).
- Load assembly:
  - Beat data is captured on mem_rvalid.
  - Result = ({beat1, beat0} >> 8*off), low 8*size bits, then sign- or zero-extended per funct3.
  - If no second beat, beat1 is treated as 0.
- RESP: rsp_valid=1 for exactly one cycle, rsp_err=0; rsp_rdata holds the result until the next response.
- Latency (gnt in same cycle as beat, rvalid next cycle):
  - Aligned access: accept at cycle 0, beat at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
  - Split access: rsp_valid at cycle 5.
- Spurious inputs: mem_rvalid outside WAIT states and mem_gnt outside BEAT states are ignored.
- Throughput: at most one request in flight; no request pipelining.

Test Plan:
- XLEN=32, LB at 0x1003; mem word 0x80FF_1234 -> mask 0001... no: beat mask 1000, rsp_rdata=0xFFFF_FF80, rsp_valid at cycle 3, req_ready=0 during cycles 1-3.
- XLEN=32, SW at 0x2002, wdata 0xAABB_CCDD, MISALIGN_EN=1:
  - Beat0 addr 0x2000, mask 1100, data 0xCCDD_0000.
  - Beat1 addr 0x2004, mask 0011, data 0x0000_AABB.
  - One rsp_valid pulse, rsp_err=0.
- XLEN=32, LHU at 0x0003, MISALIGN_EN=0 -> no mem_cs assertion; rsp_valid=1, rsp_err=1, rsp_rdata=0 one cycle after accept.
- mem_gnt withheld 4 cycles during an LW at 0x10 -> mem_cs, mem_addr=0x10, mem_mask=1111 held stable; rsp_valid asserted 4 cycles later than nominal.
- XLEN=64, LWU at 0x...0C; mem dword 0x8765_4321_0000_0000 -> mask 0xF0, rsp_rdata=0x0000_0000_8765_4321. Same setup with funct3=010 -> 0xFFFF_FFFF_8765_4321.
- rst_n pulled low in WAIT1 of a split load -> all outputs at reset values immediately; after release, a new aligned LW completes normally with no stale rsp_valid.
